// File: rtl/alu_rs_table.sv
// ALU reservation station table.
// Holds up to RS_ENT waiting ALU ops. Each entry tracks its two source tags
// with ready bits, destination, an FU steering bit and an age counter. Result
// broadcasts wake sources up. The two ALU selectors free entries via grants.
// Ports:
//   clk, reset                    clock, async active-high reset
//   disp_*                        dispatch request, sources, destination
//   disp_ready, free_cnt          at least one free entry / number of free entries
//   wk_val1/2, wk_tag1/2          result-tag broadcasts
//   grant0/1, oindex0/1           selector grants for ALU0 / ALU1
//   ageN, indexN, fuN, rdyN_0/1   per-entry view for the selectors
//   iss_dest0/1, iss_dstval0/1    destination of the granted entry
module alu_rs_table #(
    parameter int RRF_SEL = 6,
    parameter int RS_ENT  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               disp_valid,
    output logic               disp_ready,
    input  logic [RRF_SEL-1:0] disp_src1,
    input  logic [RRF_SEL-1:0] disp_src2,
    input  logic               disp_rdy1,
    input  logic               disp_rdy2,
    input  logic [RRF_SEL-1:0] disp_dest,
    input  logic               disp_dstval,
    input  logic               wk_val1,
    input  logic               wk_val2,
    input  logic [RRF_SEL-1:0] wk_tag1,
    input  logic [RRF_SEL-1:0] wk_tag2,
    input  logic               grant0,
    input  logic               grant1,
    input  logic [2:0]         oindex0,
    input  logic [2:0]         oindex1,
    output logic [RRF_SEL-1:0] age0, age1, age2, age3, age4, age5, age6, age7,
    output logic [2:0]         index0, index1, index2, index3,
    output logic [2:0]         index4, index5, index6, index7,
    output logic               fu0, fu1, fu2, fu3, fu4, fu5, fu6, fu7,
    output logic               rdy0_0, rdy1_0, rdy2_0, rdy3_0,
    output logic               rdy4_0, rdy5_0, rdy6_0, rdy7_0,
    output logic               rdy0_1, rdy1_1, rdy2_1, rdy3_1,
    output logic               rdy4_1, rdy5_1, rdy6_1, rdy7_1,
    output logic [RRF_SEL-1:0] iss_dest0,
    output logic               iss_dstval0,
    output logic [RRF_SEL-1:0] iss_dest1,
    output logic               iss_dstval1,
    output logic [3:0]         free_cnt
);

    localparam logic [RRF_SEL-1:0] AGE_MAX = {RRF_SEL{1'b1}};

    logic [RS_ENT-1:0]  busy_q, busy_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [RS_ENT-1:0]  fu_q, fu_d, dstval_q, dstval_d;
    logic [RRF_SEL-1:0] src1_q [RS_ENT];
    logic [RRF_SEL-1:0] src1_d [RS_ENT];
    logic [RRF_SEL-1:0] src2_q [RS_ENT];
    logic [RRF_SEL-1:0] src2_d [RS_ENT];
    logic [RRF_SEL-1:0] dest_q [RS_ENT];
    logic [RRF_SEL-1:0] dest_d [RS_ENT];
    logic [RRF_SEL-1:0] age_q  [RS_ENT];
    logic [RRF_SEL-1:0] age_d  [RS_ENT];
    logic               toggle_q, toggle_d;

    logic [RS_ENT-1:0]  ready0, ready1;
    logic [2:0]         alloc_idx;
    logic               accept, clr0, clr1;

    function automatic logic wk_hit(input logic [RRF_SEL-1:0] tag,
                                    input logic v1, input logic [RRF_SEL-1:0] t1,
                                    input logic v2, input logic [RRF_SEL-1:0] t2);
        return (v1 && (t1 == tag)) || (v2 && (t2 == tag));
    endfunction

    assign ready0 = busy_q & rdy1_q & rdy2_q & ~fu_q;
    assign ready1 = busy_q & rdy1_q & rdy2_q & fu_q;

    assign disp_ready = ~(&busy_q);
    assign accept     = disp_valid && disp_ready;
    // Grants only count when the named entry is actually issuable on that ALU.
    assign clr0       = grant0 && ready0[oindex0];
    assign clr1       = grant1 && ready1[oindex1];

    // Lowest-numbered free entry, based on this cycle's busy bits only.
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_ENT - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = 3'(i);
        end
    end

    always_comb begin
        free_cnt = '0;
        for (int i = 0; i < RS_ENT; i++) begin
            free_cnt = free_cnt + {3'b000, ~busy_q[i]};
        end
    end

    always_comb begin
        busy_d   = busy_q;
        rdy1_d   = rdy1_q;
        rdy2_d   = rdy2_q;
        fu_d     = fu_q;
        dstval_d = dstval_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        dest_d   = dest_q;
        age_d    = age_q;
        toggle_d = toggle_q;
        for (int i = 0; i < RS_ENT; i++) begin
            if (busy_q[i]) begin
                if (wk_hit(src1_q[i], wk_val1, wk_tag1, wk_val2, wk_tag2)) rdy1_d[i] = 1'b1;
                if (wk_hit(src2_q[i], wk_val1, wk_tag1, wk_val2, wk_tag2)) rdy2_d[i] = 1'b1;
                if (age_q[i] != AGE_MAX) age_d[i] = age_q[i] + RRF_SEL'(1);
            end
        end
        if (clr0) busy_d[oindex0] = 1'b0;
        if (clr1) busy_d[oindex1] = 1'b0;
        // The allocated entry was free this cycle, so no grant can touch it.
        if (accept) begin
            busy_d[alloc_idx]   = 1'b1;
            src1_d[alloc_idx]   = disp_src1;
            src2_d[alloc_idx]   = disp_src2;
            rdy1_d[alloc_idx]   = disp_rdy1 || wk_hit(disp_src1, wk_val1, wk_tag1, wk_val2, wk_tag2);
            rdy2_d[alloc_idx]   = disp_rdy2 || wk_hit(disp_src2, wk_val1, wk_tag1, wk_val2, wk_tag2);
            dest_d[alloc_idx]   = disp_dest;
            dstval_d[alloc_idx] = disp_dstval;
            fu_d[alloc_idx]     = toggle_q;
            age_d[alloc_idx]    = '0;
            toggle_d            = ~toggle_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q   <= '0;
            rdy1_q   <= '0;
            rdy2_q   <= '0;
            fu_q     <= '0;
            dstval_q <= '0;
            toggle_q <= 1'b0;
            for (int i = 0; i < RS_ENT; i++) begin
                src1_q[i] <= '0;
                src2_q[i] <= '0;
                dest_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            busy_q   <= busy_d;
            rdy1_q   <= rdy1_d;
            rdy2_q   <= rdy2_d;
            fu_q     <= fu_d;
            dstval_q <= dstval_d;
            toggle_q <= toggle_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            dest_q   <= dest_d;
            age_q    <= age_d;
        end
    end

    assign iss_dest0   = grant0 ? dest_q[oindex0]   : '0;
    assign iss_dstval0 = grant0 ? dstval_q[oindex0] : 1'b0;
    assign iss_dest1   = grant1 ? dest_q[oindex1]   : '0;
    assign iss_dstval1 = grant1 ? dstval_q[oindex1] : 1'b0;

    assign {rdy7_0, rdy6_0, rdy5_0, rdy4_0, rdy3_0, rdy2_0, rdy1_0, rdy0_0} = ready0;
    assign {rdy7_1, rdy6_1, rdy5_1, rdy4_1, rdy3_1, rdy2_1, rdy1_1, rdy0_1} = ready1;
    assign {fu7, fu6, fu5, fu4, fu3, fu2, fu1, fu0} = fu_q;

    // Free entries report age 0 so the selector never sees stale ages.
    assign age0 = busy_q[0] ? age_q[0] : '0;
    assign age1 = busy_q[1] ? age_q[1] : '0;
    assign age2 = busy_q[2] ? age_q[2] : '0;
    assign age3 = busy_q[3] ? age_q[3] : '0;
    assign age4 = busy_q[4] ? age_q[4] : '0;
    assign age5 = busy_q[5] ? age_q[5] : '0;
    assign age6 = busy_q[6] ? age_q[6] : '0;
    assign age7 = busy_q[7] ? age_q[7] : '0;

    assign index0 = 3'd0;
    assign index1 = 3'd1;
    assign index2 = 3'd2;
    assign index3 = 3'd3;
    assign index4 = 3'd4;
    assign index5 = 3'd5;
    assign index6 = 3'd6;
    assign index7 = 3'd7;

endmodule

// File: tb/tb_alu_rs_table.sv
// Testbench for alu_rs_table: directed stimulus, expected values queued at
// stimulus time and compared when the DUT output is observed.
module tb_alu_rs_table;

    logic       clk = 1'b0;
    logic       reset;
    logic       disp_valid, disp_ready, disp_rdy1, disp_rdy2, disp_dstval;
    logic [5:0] disp_src1, disp_src2, disp_dest;
    logic       wk_val1, wk_val2;
    logic [5:0] wk_tag1, wk_tag2;
    logic       grant0, grant1;
    logic [2:0] oindex0, oindex1;
    logic [5:0] age0, age1, age2, age3, age4, age5, age6, age7;
    logic [2:0] index0, index1, index2, index3, index4, index5, index6, index7;
    logic       fu0, fu1, fu2, fu3, fu4, fu5, fu6, fu7;
    logic       rdy0_0, rdy1_0, rdy2_0, rdy3_0, rdy4_0, rdy5_0, rdy6_0, rdy7_0;
    logic       rdy0_1, rdy1_1, rdy2_1, rdy3_1, rdy4_1, rdy5_1, rdy6_1, rdy7_1;
    logic [5:0] iss_dest0, iss_dest1;
    logic       iss_dstval0, iss_dstval1;
    logic [3:0] free_cnt;

    logic [7:0]  rdy0_v, rdy1_v, fu_v;
    logic [5:0]  age_or;
    logic [23:0] idx_v;

    assign rdy0_v = {rdy7_0, rdy6_0, rdy5_0, rdy4_0, rdy3_0, rdy2_0, rdy1_0, rdy0_0};
    assign rdy1_v = {rdy7_1, rdy6_1, rdy5_1, rdy4_1, rdy3_1, rdy2_1, rdy1_1, rdy0_1};
    assign fu_v   = {fu7, fu6, fu5, fu4, fu3, fu2, fu1, fu0};
    assign age_or = age0 | age1 | age2 | age3 | age4 | age5 | age6 | age7;
    assign idx_v  = {index7, index6, index5, index4, index3, index2, index1, index0};

    alu_rs_table #(.RRF_SEL(6), .RS_ENT(8)) dut (
        .clk(clk), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_src1(disp_src1), .disp_src2(disp_src2),
        .disp_rdy1(disp_rdy1), .disp_rdy2(disp_rdy2),
        .disp_dest(disp_dest), .disp_dstval(disp_dstval),
        .wk_val1(wk_val1), .wk_val2(wk_val2), .wk_tag1(wk_tag1), .wk_tag2(wk_tag2),
        .grant0(grant0), .grant1(grant1), .oindex0(oindex0), .oindex1(oindex1),
        .age0(age0), .age1(age1), .age2(age2), .age3(age3),
        .age4(age4), .age5(age5), .age6(age6), .age7(age7),
        .index0(index0), .index1(index1), .index2(index2), .index3(index3),
        .index4(index4), .index5(index5), .index6(index6), .index7(index7),
        .fu0(fu0), .fu1(fu1), .fu2(fu2), .fu3(fu3), .fu4(fu4), .fu5(fu5), .fu6(fu6), .fu7(fu7),
        .rdy0_0(rdy0_0), .rdy1_0(rdy1_0), .rdy2_0(rdy2_0), .rdy3_0(rdy3_0),
        .rdy4_0(rdy4_0), .rdy5_0(rdy5_0), .rdy6_0(rdy6_0), .rdy7_0(rdy7_0),
        .rdy0_1(rdy0_1), .rdy1_1(rdy1_1), .rdy2_1(rdy2_1), .rdy3_1(rdy3_1),
        .rdy4_1(rdy4_1), .rdy5_1(rdy5_1), .rdy6_1(rdy6_1), .rdy7_1(rdy7_1),
        .iss_dest0(iss_dest0), .iss_dstval0(iss_dstval0),
        .iss_dest1(iss_dest1), .iss_dstval1(iss_dstval1),
        .free_cnt(free_cnt)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_empty: got output %0h with no expected value queued", obs);
        end else begin
            chk_val(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        grant0     = 1'b0;
        grant1     = 1'b0;
        wk_val1    = 1'b0;
        wk_val2    = 1'b0;
    endtask

    task automatic disp(input logic [5:0] s1, input logic r1, input logic [5:0] s2,
                        input logic r2, input logic [5:0] dst);
        disp_valid  = 1'b1;
        disp_src1   = s1;
        disp_rdy1   = r1;
        disp_src2   = s2;
        disp_rdy2   = r2;
        disp_dest   = dst;
        disp_dstval = 1'b1;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        disp_src1 = '0; disp_src2 = '0; disp_dest = '0;
        disp_rdy1 = 1'b0; disp_rdy2 = 1'b0; disp_dstval = 1'b0;
        wk_tag1 = '0; wk_tag2 = '0; oindex0 = '0; oindex1 = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;

        // Reset state
        sb_push("rst_free", 8);  sb_push("rst_drdy", 1);
        sb_push("rst_rdy0", 0);  sb_push("rst_rdy1", 0);
        sb_push("rst_iss0", 0);  sb_push("rst_age", 0);
        sb_push("index", 24'hFAC688);
        sb_pop(free_cnt); sb_pop(disp_ready); sb_pop(rdy0_v); sb_pop(rdy1_v);
        sb_pop(iss_dest0); sb_pop(age_or); sb_pop(idx_v);

        // First dispatch, both sources ready -> entry 0 on ALU0
        disp(3, 1, 5, 1, 9);
        sb_push("d0_free", 7); sb_push("d0_fu0", 0); sb_push("d0_rdy0", 8'h01); sb_push("d0_rdy1", 0);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(fu0); sb_pop(rdy0_v); sb_pop(rdy1_v);

        // Source not ready, woken by a later broadcast
        disp(7, 0, 1, 1, 10);
        sb_push("d1_rdy1", 0); sb_push("d1_free", 6); sb_push("d1_fu1", 1);
        tick(); idle();
        sb_pop(rdy1_v); sb_pop(free_cnt); sb_pop(fu1);
        wk_val1 = 1'b1; wk_tag1 = 7;
        sb_push("wk_same_cyc", 0);
        @(negedge clk); sb_pop(rdy1_v);
        tick(); idle();
        sb_push("wk_next_cyc", 8'h02);
        sb_pop(rdy1_v);

        // Bypass: both sources broadcast in the dispatch cycle -> entry 2 ready
        disp(20, 0, 21, 0, 22);
        wk_val1 = 1'b1; wk_tag1 = 20; wk_val2 = 1'b1; wk_tag2 = 21;
        sb_push("byp_rdy0", 8'h05); sb_push("byp_free", 5); sb_push("byp_fu2", 0);
        tick(); idle();
        sb_pop(rdy0_v); sb_pop(free_cnt); sb_pop(fu2);

        // Grant entry 2 on ALU0 while dispatching -> new op lands in entry 3
        grant0 = 1'b1; oindex0 = 2;
        disp(33, 1, 34, 1, 30);
        sb_push("g0_dest", 22); sb_push("g0_dval", 1);
        @(negedge clk); sb_pop(iss_dest0); sb_pop(iss_dstval0);
        sb_push("g0_free", 5); sb_push("g0_rdy0", 8'h01); sb_push("g0_rdy1", 8'h0A);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(rdy0_v); sb_pop(rdy1_v);

        // Freed entry 2 is reused one cycle later
        disp(1, 1, 2, 1, 40);
        sb_push("reuse_rdy0", 8'h05); sb_push("reuse_free", 4);
        tick(); idle();
        sb_pop(rdy0_v); sb_pop(free_cnt);

        // Entry 4 on ALU1 with an unready source
        disp(50, 0, 1, 1, 41);
        sb_push("e4_free", 3); sb_push("e4_rdy1", 8'h0A); sb_push("e4_fu4", 1);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(rdy1_v); sb_pop(fu4);

        // grant1 to a non-ready entry is ignored
        grant1 = 1'b1; oindex1 = 4;
        sb_push("g1_nrdy_free", 3); sb_push("g1_nrdy_rdy1", 8'h0A);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(rdy1_v);

        // grant1 to an ALU0 entry is ignored
        grant1 = 1'b1; oindex1 = 0;
        sb_push("g1_fu0_free", 3); sb_push("g1_fu0_rdy0", 8'h05);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(rdy0_v);

        // Legal grant1 on entry 1
        grant1 = 1'b1; oindex1 = 1;
        sb_push("g1_dest", 10); sb_push("g1_dval", 1);
        @(negedge clk); sb_pop(iss_dest1); sb_pop(iss_dstval1);
        sb_push("g1_free", 4); sb_push("g1_rdy1", 8'h08);
        tick(); idle();
        sb_pop(free_cnt); sb_pop(rdy1_v);

        // Asynchronous reset mid-stream, away from any clock edge
        reset = 1'b1;
        #2;
        sb_push("arst_free", 8); sb_push("arst_drdy", 1); sb_push("arst_rdy0", 0);
        sb_push("arst_rdy1", 0); sb_push("arst_fu", 0);   sb_push("arst_age", 0);
        sb_pop(free_cnt); sb_pop(disp_ready); sb_pop(rdy0_v);
        sb_pop(rdy1_v); sb_pop(fu_v); sb_pop(age_or);
        disp(1, 1, 1, 1, 1);
        sb_push("rst_hold_free", 8);
        tick(); idle();
        sb_pop(free_cnt);
        reset = 1'b0;
        #1;

        // Fill all eight entries, fu alternates
        for (int i = 0; i < 8; i++) begin
            disp(6'(i), 1, 6'(i + 1), 1, 6'(8 + i));
            sb_push($sformatf("fill%0d_free", i), 7 - i);
            tick(); idle();
            sb_pop(free_cnt);
        end
        sb_push("full_drdy", 0); sb_push("full_fu", 8'hAA);
        sb_pop(disp_ready); sb_pop(fu_v);

        // Ninth dispatch ignored
        disp(1, 1, 1, 1, 63);
        sb_push("ninth_free", 0);
        tick(); idle();
        sb_pop(free_cnt);
        grant0 = 1'b1; oindex0 = 0;
        sb_push("ninth_dest0", 8);
        @(negedge clk); sb_pop(iss_dest0);
        sb_push("ninth_g_free", 1);
        tick(); idle();
        sb_pop(free_cnt);
        // Toggle must not have moved on the rejected dispatch
        disp(1, 1, 1, 1, 44);
        sb_push("refill_fu0", 0); sb_push("refill_rdy0", 8'h55); sb_push("refill_free", 0);
        tick(); idle();
        sb_pop(fu0); sb_pop(rdy0_v); sb_pop(free_cnt);

        // Age counting and saturation
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        disp(60, 0, 61, 0, 5);
        tick(); idle();
        sb_push("age_alloc", 0); sb_push("age_free_ent", 0);
        sb_pop(age0); sb_pop(age1);
        tick();
        sb_push("age_1", 1);
        sb_pop(age0);
        repeat (62) tick();
        sb_push("age_63", 63);
        sb_pop(age0);
        repeat (8) tick();
        sb_push("age_sat", 63);
        sb_pop(age0);

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_leftover: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
